// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over a window, then scans the counts
// one channel per cycle to publish argmax, its count and a tie flag.
module spike_rate_decoder #(
  parameter int CHANNELS = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  localparam int IDX_W = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clear,
  input  logic [CHANNELS-1:0] spikes_in,
  input  logic [WIN_W-1:0]    window_len,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    winner_idx,
  output logic [CNT_W-1:0]    winner_cnt,
  output logic                tie,
  input  logic [IDX_W-1:0]    sel,
  output logic [CNT_W-1:0]    sel_cnt
);
  typedef enum logic [1:0] {IDLE, COUNT, COMPARE, DONE} state_t;
  state_t state_q, state_d;
  logic [WIN_W-1:0] win_rem;
  logic [IDX_W-1:0] k, bidx, nxt_idx;
  logic [CNT_W-1:0] cnt [CHANNELS];
  logic [CNT_W-1:0] lat [CHANNELS];
  logic [CNT_W-1:0] best, cur, nxt_best;
  logic tie_q, nxt_tie, take, last;
  assign busy = state_q == COUNT || state_q == COMPARE;
  assign done = state_q == DONE;
  assign sel_cnt = lat[sel];
  assign cur = cnt[k];
  assign last = k == IDX_W'(CHANNELS - 1);
  // index 0 seeds the scan; a strictly larger count takes over, an equal one flags a tie
  assign take = k == '0 || cur > best;
  assign nxt_best = take ? cur : best;
  assign nxt_idx = take ? k : bidx;
  assign nxt_tie = !take && (cur == best || tie_q);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = en ? (window_len == '0 ? COMPARE : COUNT) : IDLE;
      COUNT:      state_d = !en ? IDLE : (win_rem == WIN_W'(1) ? COMPARE : COUNT);
      COMPARE:    state_d = last ? DONE : COMPARE;
    endcase
    if (clear) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_rem <= '0;
      k <= '0;
      best <= '0;
      bidx <= '0;
      tie_q <= 1'b0;
      winner_idx <= '0;
      winner_cnt <= '0;
      tie <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
        lat[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (clear) begin
        winner_idx <= '0;
        winner_cnt <= '0;
        tie <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
          cnt[c] <= '0;
          lat[c] <= '0;
        end
      end else begin
        unique case (state_q)
          IDLE, DONE: if (en) begin
            win_rem <= window_len;
            k <= '0;
            for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
          end
          COUNT: begin
            win_rem <= win_rem - WIN_W'(1);
            for (int c = 0; c < CHANNELS; c++)
              if (!en) cnt[c] <= '0;
              else if (spikes_in[c] && ~&cnt[c]) cnt[c] <= cnt[c] + CNT_W'(1);
          end
          COMPARE: begin
            k <= k + IDX_W'(1);
            best <= nxt_best;
            bidx <= nxt_idx;
            tie_q <= nxt_tie;
            if (last) begin
              winner_idx <= nxt_idx;
              winner_cnt <= nxt_best;
              tie <= nxt_tie;
              for (int c = 0; c < CHANNELS; c++) lat[c] <= cnt[c];
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: random windows against a count-then-argmax model, on an 8-bit
// and a 4-bit counter instance sharing the same stimulus.
module tb_spike_rate_decoder;
  localparam int CH = 8;
  logic clk = 0, rst_n = 0, en = 0, clear = 0;
  logic [CH-1:0] spikes_in = '0;
  logic [7:0] window_len = '0;
  logic [2:0] sel = '0;
  logic busy8, done8, tie8, busy4, done4, tie4;
  logic [2:0] idx8, idx4;
  logic [7:0] cnt8, sc8;
  logic [3:0] cnt4, sc4;
  int n_vec = 0, n_err = 0, cyc = 0, done_cyc = 0;
  int m[CH];
  int e_idx8, e_cnt8, e_idx4, e_cnt4;
  bit e_tie8, e_tie4;
  int e_lat8[CH], e_lat4[CH];
  logic [CH-1:0] pat[$];

  spike_rate_decoder dut8 (.clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .spikes_in(spikes_in),
    .window_len(window_len), .busy(busy8), .done(done8), .winner_idx(idx8), .winner_cnt(cnt8),
    .tie(tie8), .sel(sel), .sel_cnt(sc8));
  spike_rate_decoder #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
    .spikes_in(spikes_in), .window_len(window_len), .busy(busy4), .done(done4), .winner_idx(idx4),
    .winner_cnt(cnt4), .tie(tie4), .sel(sel), .sel_cnt(sc4));

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void winner(input int v[CH], output int idx, output int mx, output bit t);
    int n_eq;
    mx = 0;
    foreach (v[c]) if (v[c] > mx) mx = v[c];
    n_eq = 0;
    idx = -1;
    foreach (v[c]) if (v[c] == mx) begin
      if (idx < 0) idx = c;
      n_eq++;
    end
    t = n_eq > 1;
  endfunction

  task automatic model();
    foreach (m[c]) begin
      e_lat8[c] = m[c] > 255 ? 255 : m[c];
      e_lat4[c] = m[c] > 15 ? 15 : m[c];
    end
    winner(e_lat8, e_idx8, e_cnt8, e_tie8);
    winner(e_lat4, e_idx4, e_cnt4, e_tie4);
  endtask

  task automatic zero_model();
    foreach (m[c]) m[c] = 0;
    foreach (e_lat8[c]) begin
      e_lat8[c] = 0;
      e_lat4[c] = 0;
    end
    e_idx8 = 0; e_cnt8 = 0; e_tie8 = 0;
    e_idx4 = 0; e_cnt4 = 0; e_tie4 = 0;
  endtask

  task automatic check_results(input string tag);
    chk({tag, " idx8"}, idx8, e_idx8);
    chk({tag, " cnt8"}, cnt8, e_cnt8);
    chk({tag, " tie8"}, tie8, e_tie8);
    chk({tag, " idx4"}, idx4, e_idx4);
    chk({tag, " cnt4"}, cnt4, e_cnt4);
    chk({tag, " tie4"}, tie4, e_tie4);
    for (int c = 0; c < CH; c++) begin
      sel = 3'(c);
      #1;
      chk({tag, " sel_cnt8"}, sc8, e_lat8[c]);
      chk({tag, " sel_cnt4"}, sc4, e_lat4[c]);
    end
  endtask

  task automatic idle_no_done(input string tag, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done8 || done4 || busy8 || busy4) seen = 1;
    end
    chk({tag, " quiet"}, seen, 0);
  endtask

  // one full window starting in the current cycle; keep leaves en high for continuous mode
  task automatic run_window(input string tag, input int n, input bit keep);
    int w;
    window_len = 8'(n);
    en = 1;
    spikes_in = CH'($urandom);
    foreach (m[c]) m[c] = 0;
    tick();
    for (int i = 0; i < n; i++) begin
      spikes_in = pat.size() > 0 ? pat.pop_front() : CH'($urandom & $urandom);
      foreach (m[c]) m[c] += spikes_in[c];
      if (i == 0) chk({tag, " busy"}, busy8 && busy4, 1);
      tick();
    end
    en = keep;
    spikes_in = CH'($urandom);
    w = 0;
    while (!done8 && w < 40) begin
      tick();
      w++;
    end
    chk({tag, " latency"}, w, 8);
    chk({tag, " done4"}, done4, 1);
    chk({tag, " busy_done"}, busy8, 0);
    done_cyc = cyc;
    model();
    check_results(tag);
    if (!keep) begin
      tick();
      chk({tag, " done_pulse"}, done8 || done4, 0);
      chk({tag, " idle"}, busy8, 0);
    end
  endtask

  initial begin
    int d1;
    zero_model();
    for (int i = 0; i < 5; i++) begin
      spikes_in = CH'($urandom);
      en = 1'($urandom);
      tick();
    end
    check_results("reset");
    chk("reset done", done8 || busy8 || done4 || busy4, 0);
    en = 0;
    rst_n = 1;
    idle_no_done("post_reset", 20);

    for (int i = 0; i < 10; i++) pat.push_back(CH'(8'h08 | (i < 4 ? 8'h20 : 8'h00)));
    run_window("basic", 10, 0);
    chk("basic fixed idx", e_idx8, 3);

    for (int i = 0; i < 8; i++) pat.push_back(CH'(i < 3 ? 8'h45 : i < 5 ? 8'h44 : 8'h00));
    run_window("tie", 8, 0);

    for (int i = 0; i < 20; i++) pat.push_back('1);
    run_window("sat", 20, 0);

    run_window("zero_win", 0, 0);

    run_window("cont0", 4, 1);
    d1 = done_cyc;
    run_window("cont1", 4, 1);
    chk("cont period", done_cyc - d1, 13);
    d1 = done_cyc;
    run_window("cont2", 4, 0);
    chk("cont period2", done_cyc - d1, 13);

    window_len = 10;
    en = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      spikes_in = CH'($urandom);
      tick();
    end
    en = 0;
    tick();
    chk("abort busy", busy8 || busy4, 0);
    idle_no_done("abort", 15);
    check_results("abort");

    window_len = 5;
    en = 1;
    tick();
    en = 0;
    for (int i = 0; i < 5 + 3; i++) begin
      en = 1;
      spikes_in = '1;
      tick();
    end
    chk("mid_compare busy", busy8, 1);
    rst_n = 0;
    #1;
    zero_model();
    chk("async busy", busy8 || busy4 || done8 || done4, 0);
    check_results("async");
    en = 0;
    tick();
    rst_n = 1;
    idle_no_done("after_async", 12);
    check_results("after_async");

    run_window("pre_clear", 12, 0);
    window_len = 10;
    en = 1;
    tick();
    tick();
    tick();
    clear = 1;
    tick();
    clear = 0;
    en = 0;
    zero_model();
    chk("clear busy", busy8 || busy4 || done8 || done4, 0);
    check_results("clear");
    idle_no_done("after_clear", 12);

    for (int r = 0; r < 16; r++) begin
      int n = $urandom_range(0, 40);
      bit keep = 1'($urandom);
      run_window("rand", n, keep);
      if (!keep && $urandom_range(0, 1) == 1) idle_no_done("rand_gap", $urandom_range(1, 4));
    end
    en = 0;
    idle_no_done("tail", 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
